// File: rtl/winograd_pointwise_accum_sched_pkg.sv
// Shared definitions for the Winograd F(4x4,3x3) pointwise-multiply sequencer.
//   TILE            : transformed tile edge (6)
//   sched_state_t   : sequencer states
//   tile16_t/32_t   : operand and product tiles
//   tile_acc_t      : accumulator tile at the default accumulator width
package winograd_sched_pkg;
   localparam int TILE      = 6;
   localparam int CNT_W_DEF = 8;
   localparam int ACC_W_DEF = 40;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} sched_state_t;

   typedef logic [15:0]          tile16_t   [TILE][TILE];
   typedef logic [31:0]          tile32_t   [TILE][TILE];
   typedef logic [ACC_W_DEF-1:0] tile_acc_t [TILE][TILE];
endpackage

// File: rtl/winograd_pointwise_accum_sched_if.sv
// Bus bundle for the sequencer: input pair stream, multiplier drive/observe,
// and the accumulated-tile output stream.
//   master : the sequencer side
//   slave  : the environment (pair source, multiplier, output-transform stage)
interface winograd_pointwise_accum_sched_if
#(
   parameter int ACC_W = winograd_sched_pkg::ACC_W_DEF
);
   import winograd_sched_pkg::*;

   logic             in_valid;
   logic             in_ready;
   tile16_t          in_a;
   tile16_t          in_b;
   logic             mul_start;
   tile16_t          mul_a;
   tile16_t          mul_b;
   tile32_t          mul_c;
   logic             mul_done;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc [TILE][TILE];

   modport master (
      input  in_valid, in_a, in_b, mul_c, mul_done, out_ready,
      output in_ready, mul_start, mul_a, mul_b, out_valid, out_acc
   );

   modport slave (
      output in_valid, in_a, in_b, mul_c, mul_done, out_ready,
      input  in_ready, mul_start, mul_a, mul_b, out_valid, out_acc
   );
endinterface

// File: rtl/winograd_pointwise_accum_sched_tile_acc.sv
// 36-lane accumulator for the channel sum of pointwise products.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero every lane (wins over add_en)
//   add_en     : acc[i][j] += zero-extended add_in[i][j]
//   add_in     : 32-bit product tile
//   acc        : ACC_W-bit accumulated tile
module tile_accumulator_6x6
   import winograd_sched_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             add_en,
   input  tile32_t          add_in,
   output logic [ACC_W-1:0] acc [TILE][TILE]
);
   always_ff @(posedge clk) begin
      for (int i = 0; i < TILE; i++) begin
         for (int j = 0; j < TILE; j++) begin
            if (!rst_n || clr)
               acc[i][j] <= '0;
            else if (add_en)
               acc[i][j] <= acc[i][j] + ACC_W'(add_in[i][j]);
         end
      end
   end
endmodule

// File: rtl/winograd_pointwise_accum_sched.sv
// Sequencer for the 6x6 pointwise-multiply stage: accepts one (input, kernel)
// tile pair per channel, issues each to the external multiplier, sums the
// products over channels and presents the summed tile downstream.
//   clk, rst_n    : clock, synchronous active-low reset
//   cfg_num_ch    : channels per tile, latched on the first pair (0 -> 1)
//   bus           : pair stream, multiplier interface, output stream
//   busy          : not idle
//   err_spurious  : sticky, mul_done arrived with nothing outstanding
//
// state  | meaning
// IDLE   | waiting for the first pair of a job
// ISSUE  | accepting the remaining pairs of the job
// DRAIN  | all pairs issued, waiting for outstanding products
// OUTPUT | summed tile held on out_acc until out_ready
module winograd_pointwise_accum_sched
   import winograd_sched_pkg::*;
#(
   parameter int MULT_LATENCY = 3,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int ACC_W        = ACC_W_DEF
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [CNT_W-1:0]                  cfg_num_ch,
   winograd_pointwise_accum_sched_if.master  bus,
   output logic                              busy,
   output logic                              err_spurious
);
   if (ACC_W < 32 + CNT_W) begin : g_acc_w_check
      $error("ACC_W must be at least 32+CNT_W");
   end
   if (MULT_LATENCY < 1) begin : g_lat_check
      $error("MULT_LATENCY must be at least 1");
   end

   sched_state_t     state, state_nx;
   logic [CNT_W-1:0] num_ch, iss_cnt, done_cnt;
   logic [CNT_W-1:0] cfg_eff;
   logic             in_hs, done_ok, last_done, acc_clr;
   logic [ACC_W-1:0] acc_q [TILE][TILE];

   assign cfg_eff   = (cfg_num_ch == '0) ? CNT_W'(1) : cfg_num_ch;
   assign in_hs     = bus.in_valid && bus.in_ready;
   // A product only counts while a job has issues outstanding.
   assign done_ok   = bus.mul_done && (state == ISSUE || state == DRAIN) &&
                      (done_cnt < num_ch);
   assign last_done = done_ok && (done_cnt + CNT_W'(1) == num_ch);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (in_hs) state_nx = (cfg_eff == CNT_W'(1)) ? DRAIN : ISSUE;
         ISSUE:  if (in_hs && (iss_cnt + CNT_W'(1) == num_ch)) state_nx = DRAIN;
         DRAIN:  if (last_done || done_cnt == num_ch) state_nx = OUTPUT;
         OUTPUT: if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE) || (state == ISSUE);
      bus.out_valid = (state == OUTPUT);
      busy          = (state != IDLE);
      acc_clr       = (state == OUTPUT) && bus.out_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         num_ch        <= '0;
         iss_cnt       <= '0;
         done_cnt      <= '0;
         bus.mul_start <= 1'b0;
         err_spurious  <= 1'b0;
      end else begin
         bus.mul_start <= in_hs;
         if (acc_clr) begin
            iss_cnt  <= '0;
            done_cnt <= '0;
         end else begin
            if (in_hs) begin
               if (state == IDLE) begin
                  num_ch  <= cfg_eff;
                  iss_cnt <= CNT_W'(1);
               end else begin
                  iss_cnt <= iss_cnt + CNT_W'(1);
               end
            end
            if (done_ok) done_cnt <= done_cnt + CNT_W'(1);
         end
         if (bus.mul_done && !done_ok) err_spurious <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < TILE; i++) begin
         for (int j = 0; j < TILE; j++) begin
            if (!rst_n) begin
               bus.mul_a[i][j] <= '0;
               bus.mul_b[i][j] <= '0;
            end else if (in_hs) begin
               bus.mul_a[i][j] <= bus.in_a[i][j];
               bus.mul_b[i][j] <= bus.in_b[i][j];
            end
         end
      end
   end

   tile_accumulator_6x6 #(.ACC_W(ACC_W)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .add_en (done_ok),
      .add_in (bus.mul_c),
      .acc    (acc_q)
   );

   always_comb bus.out_acc = acc_q;
endmodule

// File: tb/tb_winograd_pointwise_accum_sched.sv
module tb_winograd_pointwise_accum_sched;
   import winograd_sched_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] cfg;
   logic       busy, err;

   winograd_pointwise_accum_sched_if #(.ACC_W(40)) bus ();

   winograd_pointwise_accum_sched #(.MULT_LATENCY(3), .CNT_W(8), .ACC_W(40)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_num_ch   (cfg),
      .bus          (bus),
      .busy         (busy),
      .err_spurious (err)
   );

   always #5 clk = ~clk;

   // multiplier model: products appear 3 cycles after the start pulse
   logic [2:0]  pv;
   logic [31:0] p0 [TILE][TILE];
   logic [31:0] p1 [TILE][TILE];
   logic        inj = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) pv <= '0;
      else        pv <= {pv[1:0], bus.mul_start};
      for (int i = 0; i < TILE; i++)
         for (int j = 0; j < TILE; j++) begin
            p0[i][j]        <= 32'(bus.mul_a[i][j]) * 32'(bus.mul_b[i][j]);
            p1[i][j]        <= p0[i][j];
            bus.mul_c[i][j] <= p1[i][j];
         end
   end
   assign bus.mul_done = pv[2] | inj;

   int cyc = 0;
   int start_cnt = 0;
   int last_start = -1;
   always @(posedge clk) begin
      if (bus.mul_start) begin
         start_cnt++;
         last_start = cyc;
      end
      cyc++;
   end

   int n_tests = 0;
   int n_fail  = 0;
   longint unsigned exp_acc [TILE][TILE];
   int  exp_n, start_base, last_acc;
   bit  exp_err = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   // kind 0: a=av,b=bv; kind 1: a=k+1,b=bv; kind 2: random tiles
   task automatic run_pairs(input int cfgv, input int kind, input int av, input int bv,
                            input bit gaps);
      int np;
      bit ok;
      logic [15:0] a_v, b_v;
      np = (cfgv == 0) ? 1 : cfgv;
      exp_n = np;
      start_base = start_cnt;
      for (int i = 0; i < TILE; i++)
         for (int j = 0; j < TILE; j++) exp_acc[i][j] = 0;
      for (int k = 0; k < np; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         cfg = (k == 0) ? 8'(cfgv) : 8'($urandom);
         for (int i = 0; i < TILE; i++)
            for (int j = 0; j < TILE; j++) begin
               a_v = (kind == 0) ? 16'(av) : (kind == 1) ? 16'(k + 1) : 16'($urandom);
               b_v = (kind == 2) ? 16'($urandom) : 16'(bv);
               bus.in_a[i][j] = a_v;
               bus.in_b[i][j] = b_v;
               exp_acc[i][j] += longint'(a_v) * longint'(b_v);
            end
         bus.in_valid = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 50 && !ok; t++) begin
            ok = bus.in_ready;
            last_acc = cyc;
            @(negedge clk);
         end
         if (!ok) chk("accept_timeout", 0, 1);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic collect(input string tag, input int hold);
      int  waited = 0;
      bit  seen = 0;
      bit  rdy_bad = 0;
      bus.out_ready = (hold == 0);
      while (!seen && waited < 600) begin
         if (bus.out_valid) seen = 1'b1;
         else begin
            if (bus.in_ready) rdy_bad = 1'b1;
            @(negedge clk);
            waited++;
         end
      end
      chk({tag, "_out_valid_seen"}, 64'(seen), 1);
      if (seen) begin
         chk({tag, "_latency"}, 64'(cyc - last_acc), 5);
         chk({tag, "_in_ready_low"}, 64'(rdy_bad), 0);
         chk({tag, "_start_count"}, 64'(start_cnt - start_base), 64'(exp_n));
         chk({tag, "_start_timing"}, 64'(last_start - last_acc), 1);
         chk({tag, "_err"}, 64'(err), 64'(exp_err));
         for (int i = 0; i < TILE; i++)
            for (int j = 0; j < TILE; j++)
               chk($sformatf("%s_acc[%0d][%0d]", tag, i, j), 64'(bus.out_acc[i][j]),
                   exp_acc[i][j]);
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(bus.out_valid), 1);
            chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 0);
            chk({tag, "_hold_acc"}, 64'(bus.out_acc[h % TILE][(h * 5) % TILE]),
                exp_acc[h % TILE][(h * 5) % TILE]);
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         chk({tag, "_valid_dropped"}, 64'(bus.out_valid), 0);
         chk({tag, "_idle"}, 64'(busy), 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < TILE; i++)
         for (int j = 0; j < TILE; j++) begin
            bus.in_a[i][j] = '0;
            bus.in_b[i][j] = '0;
         end
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 1);
      chk("rst_out_valid", 64'(bus.out_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_mul_start", 64'(bus.mul_start), 0);
      chk("rst_out_acc", 64'(bus.out_acc[5][5]), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_pairs(1, 0, 2, 3, 1'b0);
      collect("n1", 0);

      run_pairs(4, 1, 0, 10, 1'b0);
      collect("n4", 0);

      run_pairs(255, 0, 16'hFFFF, 16'hFFFF, 1'b1);
      chk("n255_expected_model", exp_acc[0][0], 64'd1095183237375);
      collect("n255", 0);

      run_pairs(2, 2, 0, 0, 1'b0);
      collect("hold10", 10);
      run_pairs(3, 2, 0, 0, 1'b0);
      collect("after_hold", 0);

      for (int r = 0; r < 4; r++) begin
         run_pairs($urandom_range(2, 8), 2, 0, 0, 1'b1);
         collect($sformatf("rnd%0d", r), $urandom_range(0, 3));
      end

      run_pairs(0, 0, 1, 1, 1'b0);
      collect("cfg0", 0);

      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      @(negedge clk);
      chk("spur_err_set", 64'(err), 1);
      chk("spur_acc_untouched", 64'(bus.out_acc[2][3]), 0);
      chk("spur_idle", 64'(busy), 0);
      repeat (3) @(negedge clk);
      chk("spur_err_sticky", 64'(err), 1);
      exp_err = 1'b1;
      run_pairs(3, 2, 0, 0, 1'b0);
      collect("post_spur", 0);

      run_pairs(3, 0, 1, 1, 1'b0);
      @(negedge clk);
      chk("drain_busy", 64'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_in_ready", 64'(bus.in_ready), 1);
      chk("mid_rst_out_valid", 64'(bus.out_valid), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_err", 64'(err), 0);
      chk("mid_rst_mul_start", 64'(bus.mul_start), 0);
      chk("mid_rst_mul_a", 64'(bus.mul_a[1][4]), 0);
      chk("mid_rst_out_acc", 64'(bus.out_acc[0][0]), 0);
      exp_err = 1'b0;
      @(negedge clk);
      run_pairs(1, 0, 2, 5, 1'b0);
      collect("post_rst", 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
